// File: rtl/clk_div_buf.sv
// clk_div_buf: reference-clock buffer with per-channel glitch-free programmable dividers
module clk_div_buf #(
  parameter int NUM_CH    = 2,
  parameter int DIV_W     = 4,
  parameter int DIV_RESET = 2
) (
  input  logic                    I,
  input  logic                    CLR,
  input  logic                    IB,
  input  logic                    CEB,
  output logic                    O,
  input  logic [NUM_CH-1:0]       CE,
  input  logic [NUM_CH*DIV_W-1:0] DIV,
  output logic [NUM_CH-1:0]       ODIV,
  output logic [NUM_CH-1:0]       TC,
  output logic [NUM_CH-1:0]       RUN
);
  typedef enum logic {S_IDLE, S_RUN} state_t;
  logic unused;
  assign unused = IB;
  assign O = CEB ? 1'b0 : I;
  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    state_t st;
    logic [DIV_W-1:0] cnt, dl, d_raw, deff, cnt1;
    logic [DIV_W:0] h;
    logic last, odiv, tc, run;
    assign d_raw = DIV[k*DIV_W +: DIV_W];
    assign deff  = (d_raw[DIV_W-1:1] == '0) ? DIV_W'(2) : d_raw;
    assign h     = ({1'b0, dl} + 1'b1) >> 1;
    assign cnt1  = cnt + 1'b1;
    assign last  = cnt == dl - 1'b1;
    always_ff @(posedge I)
      if (CLR) begin
        st   <= S_IDLE;
        cnt  <= '0;
        dl   <= DIV_W'(DIV_RESET);
        odiv <= 1'b0;
        tc   <= 1'b0;
        run  <= 1'b0;
      end else if (st == S_IDLE) begin
        tc <= 1'b0;
        if (CE[k]) begin
          st   <= S_RUN;
          cnt  <= '0;
          dl   <= deff;
          odiv <= 1'b1;
          run  <= 1'b1;
        end
      end else if (!last) begin
        cnt  <= cnt1;
        odiv <= {1'b0, cnt1} < h;
        tc   <= cnt1 == dl - 1'b1;
      end else if (CE[k]) begin
        cnt  <= '0;
        dl   <= deff;
        odiv <= 1'b1;
        tc   <= 1'b0;
      end else begin
        st   <= S_IDLE;
        cnt  <= '0;
        odiv <= 1'b0;
        tc   <= 1'b0;
        run  <= 1'b0;
      end
    assign ODIV[k] = odiv;
    assign TC[k]   = tc;
    assign RUN[k]  = run;
  end
endmodule
